// File: rtl/wb_arbiter_pkg.sv
// Shared writeback types: completion request record and the regfile/ID forwarding view.
// Pure definitions; no latency or backpressure.
package wb_arbiter_pkg;

    localparam int XLEN        = 32;
    localparam int RF_IDX_BITS = 5;

    typedef struct packed {
        logic                   rd_we;
        logic [RF_IDX_BITS-1:0] rd_s;
        logic [XLEN-1:0]        rd_v;
    } wb_req_t;

    typedef struct packed {
        logic                   we;
        logic [RF_IDX_BITS-1:0] rd_s;
        logic [XLEN-1:0]        rd_v;
    } wb_id_t;

    // Source-index width; a single source still gets a 1-bit index.
    function automatic int src_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Completion-source handshake and regfile write/retire bus of the writeback stage.
// Slave is the arbiter; master is whoever drives the completion sources.
interface wb_arbiter_if #(
    parameter int NUM_SRC = 3
);
    import wb_arbiter_pkg::*;

    localparam int SRC_W = src_w(NUM_SRC);

    logic [NUM_SRC-1:0]             src_valid_i;
    logic [NUM_SRC-1:0]             src_ready_o;
    logic [NUM_SRC-1:0]             src_rd_we_i;
    logic [NUM_SRC*RF_IDX_BITS-1:0] src_rd_s_i;
    logic [NUM_SRC*XLEN-1:0]        src_rd_v_i;
    logic                           rf_we_o;
    logic [RF_IDX_BITS-1:0]         rf_rd_s_o;
    logic [XLEN-1:0]                rf_rd_v_o;
    logic                           retire_o;
    logic [SRC_W-1:0]               retire_src_o;
    logic [63:0]                    instret_o;

    modport slave (
        input  src_valid_i, src_rd_we_i, src_rd_s_i, src_rd_v_i,
        output src_ready_o, rf_we_o, rf_rd_s_o, rf_rd_v_o, retire_o, retire_src_o, instret_o
    );

    modport master (
        output src_valid_i, src_rd_we_i, src_rd_s_i, src_rd_v_i,
        input  src_ready_o, rf_we_o, rf_rd_s_o, rf_rd_v_o, retire_o, retire_src_o, instret_o
    );

endinterface

// File: rtl/wb_src_fifo.sv
// Per-source DEPTH-entry completion buffer; push visible at head one edge later.
// full_o depends on occupancy only; caller must not push when full nor pop when empty.
module wb_src_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  logic    push_i,
    input  logic    pop_i,
    input  wb_req_t din_i,
    output wb_req_t head_o,
    output logic    full_o,
    output logic    empty_o
);

    generate
        if (DEPTH == 1) begin : g_flag
            logic    r_vld;
            wb_req_t r_dat;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_vld <= 1'b0;
                end else if (push_i) begin
                    r_vld <= 1'b1;
                end else if (pop_i) begin
                    r_vld <= 1'b0;
                end
            end

            always_ff @(posedge clk_i) begin
                if (push_i) begin
                    r_dat <= din_i;
                end
            end

            assign head_o  = r_dat;
            assign full_o  = r_vld;
            assign empty_o = !r_vld;
        end else begin : g_ring
            localparam int AW = $clog2(DEPTH);

            wb_req_t       r_mem [DEPTH];
            logic [AW:0]   r_wr_ptr;
            logic [AW:0]   r_rd_ptr;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                end else begin
                    if (push_i) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
                    if (pop_i)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
                end
            end

            always_ff @(posedge clk_i) begin
                if (push_i) begin
                    r_mem[r_wr_ptr[AW-1:0]] <= din_i;
                end
            end

            // Extra pointer MSB distinguishes full from empty when the indices match.
            assign head_o  = r_mem[r_rd_ptr[AW-1:0]];
            assign empty_o = (r_wr_ptr == r_rd_ptr);
            assign full_o  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                             (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
        end
    endgenerate

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin merge of NUM_SRC buffered completion streams onto the regfile write port; 1 retire/cycle.
// Entry accepted at edge t is granted no earlier than edge t+1; src_ready_o is !full per source FIFO.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int DEPTH   = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    wb_arbiter_if.slave  bus
);

    localparam int SRC_W = src_w(NUM_SRC);

    wb_req_t                w_din  [NUM_SRC];
    wb_req_t                w_head [NUM_SRC];
    wb_req_t                w_head_sel;
    logic [NUM_SRC-1:0]     w_push;
    logic [NUM_SRC-1:0]     w_pop;
    logic [NUM_SRC-1:0]     w_full;
    logic [NUM_SRC-1:0]     w_empty;
    logic                   w_gnt_vld;
    logic [SRC_W-1:0]       w_gnt_idx;

    logic [SRC_W-1:0]       r_rr_ptr;
    logic                   r_rf_we;
    logic [RF_IDX_BITS-1:0] r_rf_rd_s;
    logic [XLEN-1:0]        r_rf_rd_v;
    logic                   r_retire;
    logic [SRC_W-1:0]       r_retire_src;
    logic [63:0]            r_instret;

    function automatic logic [SRC_W-1:0] rr_add(input logic [SRC_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_SRC) s = s - NUM_SRC;
        return SRC_W'(s);
    endfunction

    generate
        for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
            assign w_din[s]  = {bus.src_rd_we_i[s],
                                bus.src_rd_s_i[s*RF_IDX_BITS +: RF_IDX_BITS],
                                bus.src_rd_v_i[s*XLEN +: XLEN]};
            assign w_push[s] = bus.src_valid_i[s] && !w_full[s];
            assign w_pop[s]  = w_gnt_vld && (w_gnt_idx == SRC_W'(s));

            wb_src_fifo #(.DEPTH(DEPTH)) u_fifo (
                .clk_i   (clk_i),
                .rst_ni  (rst_ni),
                .push_i  (w_push[s]),
                .pop_i   (w_pop[s]),
                .din_i   (w_din[s]),
                .head_o  (w_head[s]),
                .full_o  (w_full[s]),
                .empty_o (w_empty[s])
            );
        end
    endgenerate

    assign bus.src_ready_o = ~w_full;

    // First non-empty source at or after rr_ptr, wrapping modulo NUM_SRC.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!w_gnt_vld && !w_empty[rr_add(r_rr_ptr, k)]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = rr_add(r_rr_ptr, k);
            end
        end
    end

    assign w_head_sel = w_head[w_gnt_idx];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr     <= '0;
            r_rf_we      <= 1'b0;
            r_rf_rd_s    <= '0;
            r_rf_rd_v    <= '0;
            r_retire     <= 1'b0;
            r_retire_src <= '0;
            r_instret    <= '0;
        end else begin
            r_rf_we  <= 1'b0;
            r_retire <= 1'b0;
            if (w_gnt_vld) begin
                r_rr_ptr     <= rr_add(w_gnt_idx, 1);
                // x0 writes retire but never reach the regfile.
                r_rf_we      <= w_head_sel.rd_we && (w_head_sel.rd_s != '0);
                r_rf_rd_s    <= w_head_sel.rd_s;
                r_rf_rd_v    <= w_head_sel.rd_v;
                r_retire     <= 1'b1;
                r_retire_src <= w_gnt_idx;
                r_instret    <= r_instret + 64'd1;
            end
        end
    end

    assign bus.rf_we_o      = r_rf_we;
    assign bus.rf_rd_s_o    = r_rf_rd_s;
    assign bus.rf_rd_v_o    = r_rf_rd_v;
    assign bus.retire_o     = r_retire;
    assign bus.retire_src_o = r_retire_src;
    assign bus.instret_o    = r_instret;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed vector table plus scoreboarded stream, wrap and reset sequences for wb_arbiter.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int NS = 3;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    wb_arbiter_if #(.NUM_SRC(NS)) bus ();

    wb_arbiter #(.NUM_SRC(NS), .DEPTH(2)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    typedef struct {
        logic [2:0]  vld;
        logic [2:0]  we;
        logic [14:0] rd;
        logic [95:0] v;
        logic        e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_v;
        logic        e_ret;
        logic [1:0]  e_src;
        logic [63:0] e_inst;
        logic [2:0]  e_rdy;
    } vec_t;

    int      n_cmp = 0;
    int      n_err = 0;
    bit      mon_en = 1'b0;
    wb_req_t sb_q [NS][$];
    int      ret_cnt [NS];
    vec_t    tbl [15];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] vld, input logic [2:0] we,
                         input logic [14:0] rd, input logic [95:0] v);
        bus.src_valid_i = vld;
        bus.src_rd_we_i = we;
        bus.src_rd_s_i  = rd;
        bus.src_rd_v_i  = v;
    endtask

    // One clock: log accepted pushes, advance past the edge, check any retire against the scoreboard.
    task automatic tick();
        int      g;
        wb_req_t e;
        if (mon_en) begin
            for (int s = 0; s < NS; s++) begin
                if (bus.src_valid_i[s] && bus.src_ready_o[s])
                    sb_q[s].push_back({bus.src_rd_we_i[s], bus.src_rd_s_i[s*5 +: 5], bus.src_rd_v_i[s*32 +: 32]});
            end
        end
        @(posedge clk_i);
        #1;
        if (mon_en && bus.retire_o) begin
            g = int'(bus.retire_src_o);
            if (g >= NS || sb_q[g].size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_retire: got src %0d, want no retire", g);
            end else begin
                e = sb_q[g].pop_front();
                chk($sformatf("mon_rd_s_src%0d", g), 64'(bus.rf_rd_s_o), 64'(e.rd_s));
                chk($sformatf("mon_rd_v_src%0d", g), 64'(bus.rf_rd_v_o), 64'(e.rd_v));
                chk($sformatf("mon_we_src%0d", g), 64'(bus.rf_we_o), 64'(e.rd_we && (e.rd_s != 5'd0)));
                ret_cnt[g]++;
            end
        end
    endtask

    function automatic vec_t mk(input logic [2:0] vld, input logic [2:0] we, input logic [14:0] rd,
                                input logic [95:0] v, input logic e_we, input logic [4:0] e_rd,
                                input logic [31:0] e_v, input logic e_ret, input logic [1:0] e_src,
                                input logic [63:0] e_inst, input logic [2:0] e_rdy);
        vec_t r;
        r.vld = vld; r.we = we; r.rd = rd; r.v = v;
        r.e_we = e_we; r.e_rd = e_rd; r.e_v = e_v; r.e_ret = e_ret;
        r.e_src = e_src; r.e_inst = e_inst; r.e_rdy = e_rdy;
        return r;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, want finish before timeout");
        $fatal(1);
    end

    initial begin
        logic [2:0]  acc;
        logic [14:0] rd;
        logic [95:0] v;
        logic [2:0]  vld;
        logic [2:0]  we;
        int          seq [NS];
        bit          saw_low;
        int          pushed;

        // Rows: outputs checked just after the edge that consumes that row's inputs.
        tbl[0]  = mk(3'b111, 3'b111, {5'd3, 5'd2, 5'd1}, {32'hA2, 32'hA1, 32'hA0},
                     1'b0, 5'd0, 32'h0, 1'b0, 2'd0, 64'd0, 3'b111);
        tbl[1]  = mk(3'b000, 3'b000, 15'd0, 96'd0, 1'b1, 5'd1, 32'hA0, 1'b1, 2'd0, 64'd1, 3'b111);
        tbl[2]  = mk(3'b000, 3'b000, 15'd0, 96'd0, 1'b1, 5'd2, 32'hA1, 1'b1, 2'd1, 64'd2, 3'b111);
        tbl[3]  = mk(3'b000, 3'b000, 15'd0, 96'd0, 1'b1, 5'd3, 32'hA2, 1'b1, 2'd2, 64'd3, 3'b111);
        tbl[4]  = mk(3'b010, 3'b010, {5'd0, 5'd5, 5'd0}, {32'h0, 32'hDEADBEEF, 32'h0},
                     1'b0, 5'd3, 32'hA2, 1'b0, 2'd0, 64'd3, 3'b111);
        tbl[5]  = mk(3'b000, 3'b000, 15'd0, 96'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 2'd1, 64'd4, 3'b111);
        tbl[6]  = mk(3'b001, 3'b001, 15'd0, {32'h0, 32'h0, 32'h1234},
                     1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 2'd0, 64'd4, 3'b111);
        tbl[7]  = mk(3'b000, 3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 32'h1234, 1'b1, 2'd0, 64'd5, 3'b111);
        tbl[8]  = mk(3'b100, 3'b000, {5'd7, 5'd0, 5'd0}, {32'h55, 32'h0, 32'h0},
                     1'b0, 5'd0, 32'h1234, 1'b0, 2'd0, 64'd5, 3'b111);
        tbl[9]  = mk(3'b000, 3'b000, 15'd0, 96'd0, 1'b0, 5'd7, 32'h55, 1'b1, 2'd2, 64'd6, 3'b111);
        tbl[10] = mk(3'b101, 3'b101, {5'd9, 5'd0, 5'd8}, {32'h90, 32'h0, 32'h80},
                     1'b0, 5'd7, 32'h55, 1'b0, 2'd0, 64'd6, 3'b111);
        tbl[11] = mk(3'b100, 3'b100, {5'd10, 5'd0, 5'd0}, {32'h100, 32'h0, 32'h0},
                     1'b1, 5'd8, 32'h80, 1'b1, 2'd0, 64'd7, 3'b011);
        tbl[12] = mk(3'b000, 3'b000, 15'd0, 96'd0, 1'b1, 5'd9, 32'h90, 1'b1, 2'd2, 64'd8, 3'b111);
        tbl[13] = mk(3'b000, 3'b000, 15'd0, 96'd0, 1'b1, 5'd10, 32'h100, 1'b1, 2'd2, 64'd9, 3'b111);
        tbl[14] = mk(3'b000, 3'b000, 15'd0, 96'd0, 1'b0, 5'd10, 32'h100, 1'b0, 2'd0, 64'd9, 3'b111);

        drive(3'b000, 3'b000, 15'd0, 96'd0);
        #2;
        chk("rst_rf_we", 64'(bus.rf_we_o), 64'd0);
        chk("rst_retire", 64'(bus.retire_o), 64'd0);
        chk("rst_instret", bus.instret_o, 64'd0);
        #20;
        rst_ni = 1'b1;
        #1;
        chk("rst_ready", 64'(bus.src_ready_o), 64'h7);
        chk("rst_rd_s", 64'(bus.rf_rd_s_o), 64'd0);
        chk("rst_rd_v", 64'(bus.rf_rd_v_o), 64'd0);
        chk("rst_retire_src", 64'(bus.retire_src_o), 64'd0);

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].vld, tbl[i].we, tbl[i].rd, tbl[i].v);
            tick();
            chk($sformatf("row%0d_we", i), 64'(bus.rf_we_o), 64'(tbl[i].e_we));
            chk($sformatf("row%0d_rd_s", i), 64'(bus.rf_rd_s_o), 64'(tbl[i].e_rd));
            chk($sformatf("row%0d_rd_v", i), 64'(bus.rf_rd_v_o), 64'(tbl[i].e_v));
            chk($sformatf("row%0d_retire", i), 64'(bus.retire_o), 64'(tbl[i].e_ret));
            chk($sformatf("row%0d_instret", i), bus.instret_o, tbl[i].e_inst);
            chk($sformatf("row%0d_ready", i), 64'(bus.src_ready_o), 64'(tbl[i].e_rdy));
            if (tbl[i].e_ret)
                chk($sformatf("row%0d_src", i), 64'(bus.retire_src_o), 64'(tbl[i].e_src));
        end

        // All sources saturated: 30 consecutive grants must split 10/10/10.
        mon_en  = 1'b1;
        saw_low = 1'b0;
        for (int s = 0; s < NS; s++) seq[s] = 0;
        for (int c = 0; c <= 30; c++) begin
            for (int s = 0; s < NS; s++) begin
                rd[s*5 +: 5]   = 5'(s + 1);
                v[s*32 +: 32]  = {8'(s), 24'(seq[s])};
            end
            drive(3'b111, 3'b111, rd, v);
            acc = bus.src_ready_o;
            if (!bus.src_ready_o[1]) saw_low = 1'b1;
            tick();
            for (int s = 0; s < NS; s++) if (acc[s]) seq[s]++;
            if (c == 0) for (int s = 0; s < NS; s++) ret_cnt[s] = 0;
        end
        for (int s = 0; s < NS; s++)
            chk($sformatf("sat_retires_src%0d", s), 64'(ret_cnt[s]), 64'd10);
        chk("sat_src1_ready_low", 64'(saw_low), 64'd1);
        drive(3'b000, 3'b000, 15'd0, 96'd0);
        for (int c = 0; c < 20 && (sb_q[0].size() + sb_q[1].size() + sb_q[2].size()) != 0; c++) tick();
        for (int s = 0; s < NS; s++)
            chk($sformatf("sat_drain_q%0d", s), 64'(sb_q[s].size()), 64'd0);
        tick();
        chk("sat_idle_retire", 64'(bus.retire_o), 64'd0);

        // Random stream of ~100 entries, per-source order checked by the scoreboard.
        pushed = 0;
        for (int c = 0; c < 3000 && (pushed < 100 || (sb_q[0].size() + sb_q[1].size() + sb_q[2].size()) != 0); c++) begin
            if (pushed < 100) begin
                vld = 3'($urandom);
                we  = 3'($urandom);
                rd  = 15'($urandom);
                v   = {$urandom, $urandom, $urandom};
            end else begin
                vld = 3'b000; we = 3'b000; rd = 15'd0; v = 96'd0;
            end
            drive(vld, we, rd, v);
            acc = vld & bus.src_ready_o;
            tick();
            pushed += $countones(acc);
        end
        for (int s = 0; s < NS; s++)
            chk($sformatf("rand_drain_q%0d", s), 64'(sb_q[s].size()), 64'd0);
        mon_en = 1'b0;

        // instret wraps from all-ones to zero.
        drive(3'b000, 3'b000, 15'd0, 96'd0);
        force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.r_instret;
        chk("wrap_preload", bus.instret_o, 64'hFFFF_FFFF_FFFF_FFFF);
        drive(3'b001, 3'b001, {5'd0, 5'd0, 5'd4}, {32'h0, 32'h0, 32'h77});
        tick();
        drive(3'b000, 3'b000, 15'd0, 96'd0);
        tick();
        chk("wrap_retire", 64'(bus.retire_o), 64'd1);
        chk("wrap_rd_s", 64'(bus.rf_rd_s_o), 64'd4);
        chk("wrap_instret", bus.instret_o, 64'd0);

        // Mid-cycle reset with two entries buffered in source 2.
        drive(3'b111, 3'b111, {5'd3, 5'd2, 5'd1}, {32'hC2, 32'hC1, 32'hC0});
        tick();
        drive(3'b100, 3'b100, {5'd6, 5'd0, 5'd0}, {32'hC3, 32'h0, 32'h0});
        tick();
        chk("mid_grant_src", 64'(bus.retire_src_o), 64'd1);
        drive(3'b000, 3'b000, 15'd0, 96'd0);
        #3;
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_we", 64'(bus.rf_we_o), 64'd0);
        chk("mid_rst_retire", 64'(bus.retire_o), 64'd0);
        chk("mid_rst_instret", bus.instret_o, 64'd0);
        chk("mid_rst_rd_s", 64'(bus.rf_rd_s_o), 64'd0);
        chk("mid_rst_rd_v", 64'(bus.rf_rd_v_o), 64'd0);
        @(negedge clk_i);
        #2;
        rst_ni = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("post_rst%0d_retire", c), 64'(bus.retire_o), 64'd0);
            chk($sformatf("post_rst%0d_we", c), 64'(bus.rf_we_o), 64'd0);
            chk($sformatf("post_rst%0d_ready", c), 64'(bus.src_ready_o), 64'h7);
        end
        chk("post_rst_instret", bus.instret_o, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
